switch_input_mapped: RTL and testbench
======================================

// Module: switch_input_mapped
// PURPOSE
//  Memory-mapped input peripheral: the read-side counterpart of the LED output register.
//  Synchronises and debounces board switches/buttons, latches per-input change events,
//  and exposes state/events/mask on the CPU bus with an optional level interrupt.
// PARAMETERS
//  SW_WIDTH         10     number of slide-switch inputs
//  BTN_WIDTH        4      number of push-button inputs; SW_WIDTH+BTN_WIDTH <= 32
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles needed to accept a new input level (>=2)
// PORTS
//  i_clock      in   1        system clock
//  i_reset      in   1        asynchronous, active-high reset
//  i_enable     in   1        bus access request; held high until o_ready seen
//  i_rw         in   1        1 = write, 0 = read
//  i_address    in   32       byte address; only [3:2] decoded
//  i_wdata      in   32       write data
//  o_rdata      out  32       read data, valid while o_ready=1
//  o_ready      out  1        access complete
//  i_switches   in   SW_WIDTH  raw asynchronous switch levels
//  i_buttons    in   BTN_WIDTH raw asynchronous button levels
//  o_interrupt  out  1        level IRQ: |(EDGES & MASK)
// BEHAVIOUR
//  Reset: o_rdata=0, o_ready=0, o_interrupt=0, STATE=0, EDGES=0, MASK=0, debounce counters=0, armed=0.
//  Input vector in[N-1:0] = {i_buttons, i_switches}, N=SW_WIDTH+BTN_WIDTH; upper bits read 0.
//  Sync: 2-flop synchroniser per bit, reset to 0.
//  Debounce per bit: sync!=STATE -> count++; sync==STATE -> count=0;
//   count reaches DEBOUNCE_CYCLES-1 with sync!=STATE -> STATE<=sync, count=0.
//   Input-to-STATE latency = 2 (sync) + DEBOUNCE_CYCLES cycles; glitches shorter are dropped.
//  Edge latch: any STATE bit change (either direction) sets EDGES bit, but only when armed.
//   armed goes 1 after DEBOUNCE_CYCLES+2 cycles from reset release (startup settling,
//   no spurious edges from levels present at reset); stays 1 until reset.
//  Register map (i_address[3:2]):
//   0 STATE  RO    debounced levels; writes ignored
//   1 EDGES  R/W1C writing 1 clears bit; new edge in same cycle as clear -> bit stays set
//   2 MASK   RW    interrupt enable per bit
//   3 -      reads 0, writes ignored
//  Handshake: idle -> access accepted on first cycle i_enable=1 with o_ready=0;
//   next cycle o_ready=1, o_rdata holds value sampled at acceptance;
//   o_ready stays 1 while i_enable=1; drops the cycle after i_enable=0, then o_rdata=0.
//   Write side effects happen exactly once per access (acceptance cycle), never repeated
//   while i_enable is held. i_enable dropping before o_ready: access still completes.
//  o_interrupt registered: one cycle after EDGES/MASK change.
//  Reset mid-access: o_ready drops immediately; no write side effect retained.
// CONFIGURATION
//  SWITCH_INPUT_IRQ_EN defined: MASK register and o_interrupt as above.
//  Not defined: MASK reads 0, writes ignored, o_interrupt tied 0; EDGES still latched for polling.
// STRUCTURE
//  Package switch_input_pkg: register offsets (REG_STATE=2'd0, REG_EDGES=2'd1,
//   REG_MASK=2'd2), bus access state typedef (IDLE, DONE).
//  Sub-module input_debouncer (one bit: synchroniser + counter + stable level,
//   parameter DEBOUNCE_CYCLES), instantiated N times by generate; top holds edges, bus FSM, IRQ.
// TESTING (DEBOUNCE_CYCLES=4 in bench)
//  Reset with switches=10'h3FF -> after settle STATE=0x3FF, EDGES=0, o_interrupt=0.
//  Switch0 0->1 held 10 cycles -> STATE bit0=1 after 6 cycles, EDGES=0x001; 2-cycle pulse -> no change.
//  MASK=0x001 then edge on bit0 -> o_interrupt=1; write EDGES=0x001 -> EDGES=0, o_interrupt=0 next cycle.
//  W1C of bit3 in same cycle as new bit3 edge -> EDGES bit3 remains 1.
//  Hold i_enable 5 cycles on EDGES write -> single clear, o_ready 1 from cycle 2 until i_enable low.
//  Without SWITCH_INPUT_IRQ_EN: write MASK=0xFFFF -> reads 0, o_interrupt stays 0 on edges.

Source files
------------

// File: rtl/switch_input_mapped_pkg.sv
// Shared definitions for the memory-mapped switch/button input peripheral.
//   REG_STATE / REG_EDGES / REG_MASK : register offsets decoded from address bits [3:2]
//   bus_state_t                      : bus access state (IDLE, DONE)
// No ports (package).
package switch_input_pkg;

  localparam logic [1:0] REG_STATE = 2'd0;
  localparam logic [1:0] REG_EDGES = 2'd1;
  localparam logic [1:0] REG_MASK  = 2'd2;

  localparam int BUS_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } bus_state_t;

endpackage

// File: rtl/switch_input_mapped_if.sv
// CPU bus bundle for the switch input peripheral.
//   i_enable  : access request, held high until o_ready seen
//   i_rw      : 1 = write, 0 = read
//   i_address : byte address, bits [3:2] select the register
//   i_wdata   : write data
//   o_rdata   : read data, valid while o_ready = 1
//   o_ready   : access complete
// Modports: master (CPU side), slave (peripheral side).
interface switch_input_mapped_if;
  import switch_input_pkg::*;

  logic             i_enable;
  logic             i_rw;
  logic [BUS_W-1:0] i_address;
  logic [BUS_W-1:0] i_wdata;
  logic [BUS_W-1:0] o_rdata;
  logic             o_ready;

  modport master (
    output i_enable, i_rw, i_address, i_wdata,
    input  o_rdata, o_ready
  );

  modport slave (
    input  i_enable, i_rw, i_address, i_wdata,
    output o_rdata, o_ready
  );

endinterface

// File: rtl/switch_input_mapped_debouncer.sv
// input_debouncer: one input bit -> 2-flop synchroniser -> stability counter -> level.
//   Parameter DEBOUNCE_CYCLES (>= 2): consecutive differing cycles needed to accept a level.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_raw            : raw asynchronous input
//   o_level          : debounced level
//   o_toggle         : high in the cycle whose clock edge flips o_level
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_toggle
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] count;
  logic             level;

  // The edge that sees the counter at its last value with the input still
  // different is the one that commits the new level.
  assign o_toggle = (sync_p1 != level) && (count == CNT_LAST);
  assign o_level  = level;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      count   <= '0;
      level   <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter
      sync_p0 <= i_raw;
      sync_p1 <= sync_p0;
      // stability counter: any agreement restarts the count
      if (sync_p1 == level) begin
        count <= '0;
      end else if (o_toggle) begin
        level <= sync_p1;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_input_mapped.sv
// switch_input_mapped: memory-mapped switch/button input register block.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   bus              : CPU bus (switch_input_mapped_if.slave)
//   i_switches       : raw slide-switch levels (SW_WIDTH)
//   i_buttons        : raw push-button levels (BTN_WIDTH)
//   o_interrupt      : registered level IRQ, |(EDGES & MASK)
// Registers (address[3:2]): 0 STATE (RO), 1 EDGES (W1C), 2 MASK (RW), 3 reads 0.
// Optional build macro SWITCH_INPUT_IRQ_EN: enables MASK and o_interrupt;
// without it MASK reads 0 and o_interrupt is tied low (EDGES still latch for polling).
module switch_input_mapped
  import switch_input_pkg::*;
#(
  parameter int SW_WIDTH        = 10,
  parameter int BTN_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  switch_input_mapped_if.slave bus,
  input  logic [SW_WIDTH-1:0]  i_switches,
  input  logic [BTN_WIDTH-1:0] i_buttons,
  output logic                 o_interrupt
);

  localparam int               N        = SW_WIDTH + BTN_WIDTH;
  localparam int               ARM_W    = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 1);

  function automatic logic [BUS_W-1:0] zext(input logic [N-1:0] v);
    return BUS_W'(v);
  endfunction

  logic [N-1:0]     raw;
  logic [N-1:0]     state_vec;
  logic [N-1:0]     toggle_vec;
  logic [N-1:0]     edges_q;
  logic [N-1:0]     edges_d;
  logic [N-1:0]     edges_clr;
  logic [N-1:0]     mask_q;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  bus_state_t       bus_state_q;
  bus_state_t       bus_state_d;
  logic [BUS_W-1:0] rdata_q;
  logic [BUS_W-1:0] rdata_d;
  logic [BUS_W-1:0] read_val;
  logic [1:0]       reg_sel;
  logic             accept_wr;
  logic             unused_bus_bits;

  assign raw             = {i_buttons, i_switches};
  assign reg_sel         = bus.i_address[3:2];
  assign unused_bus_bits = ^{bus.i_address, bus.i_wdata};

  for (genvar g = 0; g < N; g++) begin : g_bit
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_raw   (raw[g]),
      .o_level (state_vec[g]),
      .o_toggle(toggle_vec[g])
    );
  end

  // Levels present at reset release reach STATE on the same edge that arms
  // edge capture; armed is still 0 on that edge, so they never show as events.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
      if (arm_cnt == ARM_LAST) armed <= 1'b1;
    end
  end

  // Write side effects only on the acceptance cycle (IDLE with enable).
  assign accept_wr = (bus_state_q == IDLE) && bus.i_enable && bus.i_rw;
  assign edges_clr = (accept_wr && reg_sel == REG_EDGES) ? bus.i_wdata[N-1:0] : '0;
  // A new event wins over a simultaneous clear of the same bit.
  assign edges_d   = (edges_q & ~edges_clr) | (armed ? toggle_vec : '0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) edges_q <= '0;
    else         edges_q <= edges_d;
  end

`ifdef SWITCH_INPUT_IRQ_EN
  logic irq_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (accept_wr && reg_sel == REG_MASK) mask_q <= bus.i_wdata[N-1:0];
      irq_q <= |(edges_q & mask_q);
    end
  end

  assign o_interrupt = irq_q;
`else
  assign mask_q      = '0;
  assign o_interrupt = 1'b0;
`endif

  always_comb begin
    read_val = '0;
    case (reg_sel)
      REG_STATE: read_val = zext(state_vec);
      REG_EDGES: read_val = zext(edges_q);
      REG_MASK:  read_val = zext(mask_q);
      default:   read_val = '0;
    endcase
  end

  always_comb begin
    bus_state_d = bus_state_q;
    rdata_d     = rdata_q;
    case (bus_state_q)
      IDLE: begin
        if (bus.i_enable) begin
          bus_state_d = DONE;
          rdata_d     = read_val;
        end
      end
      DONE: begin
        if (!bus.i_enable) begin
          bus_state_d = IDLE;
          rdata_d     = '0;
        end
      end
      default: begin
        bus_state_d = IDLE;
        rdata_d     = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      bus_state_q <= IDLE;
      rdata_q     <= '0;
    end else begin
      bus_state_q <= bus_state_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.o_ready = (bus_state_q == DONE);
  assign bus.o_rdata = rdata_q;

endmodule

// File: tb/tb_switch_input_mapped.sv
module tb_switch_input_mapped;

  logic       clk;
  logic       rst;
  logic [9:0] sw;
  logic [3:0] btn;
  logic       irq;

  int n_cmp;
  int n_fail;

  switch_input_mapped_if bus_if ();

  switch_input_mapped #(
    .SW_WIDTH       (10),
    .BTN_WIDTH      (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .bus        (bus_if.slave),
    .i_switches (sw),
    .i_buttons  (btn),
    .o_interrupt(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  sw;
    logic [3:0]  btn;
    int          settle;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic bus_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    bus_if.i_enable  = 1'b1;
    bus_if.i_rw      = rw;
    bus_if.i_address = addr;
    bus_if.i_wdata   = wdata;
    tick(1);
    check("ready_after_accept", {31'b0, bus_if.o_ready}, 32'd1);
    rdata = bus_if.o_rdata;
    bus_if.i_enable = 1'b0;
    tick(1);
    check("ready_drop", {31'b0, bus_if.o_ready}, 32'd0);
    check("rdata_idle", bus_if.o_rdata, 32'd0);
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    bus_access(1'b0, addr, 32'd0, r);
    check(name, r, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] r;
    bus_access(1'b1, addr, wdata, r);
  endtask

  initial begin
    logic [31:0] mask_exp;
    logic [31:0] r;
    int          bad;

`ifdef SWITCH_INPUT_IRQ_EN
    mask_exp = 32'h0000_3FFF;
`else
    mask_exp = 32'h0;
`endif

    //            sw       btn   settle rw    addr   wdata  chk   exp
    tbl[0]  = '{10'h3FE, 4'h0, 10, 1'b0, 32'h0,  32'h0,    1'b1, 32'h0000_03FE};
    tbl[1]  = '{10'h3FE, 4'h0, 0,  1'b0, 32'h4,  32'h0,    1'b1, 32'h0000_0001};
    tbl[2]  = '{10'h3FE, 4'h0, 0,  1'b1, 32'h4,  32'h1,    1'b0, 32'h0};
    tbl[3]  = '{10'h3FE, 4'h0, 0,  1'b0, 32'h4,  32'h0,    1'b1, 32'h0};
    tbl[4]  = '{10'h3FE, 4'h5, 10, 1'b0, 32'h0,  32'h0,    1'b1, 32'h0000_17FE};
    tbl[5]  = '{10'h3FE, 4'h5, 0,  1'b0, 32'h4,  32'h0,    1'b1, 32'h0000_1400};
    tbl[6]  = '{10'h3FE, 4'h5, 0,  1'b1, 32'h4,  32'h0400, 1'b0, 32'h0};
    tbl[7]  = '{10'h3FE, 4'h5, 0,  1'b0, 32'h4,  32'h0,    1'b1, 32'h0000_1000};
    tbl[8]  = '{10'h3FE, 4'h5, 0,  1'b1, 32'h0,  32'hFFFF, 1'b0, 32'h0};
    tbl[9]  = '{10'h3FE, 4'h5, 0,  1'b0, 32'h0,  32'h0,    1'b1, 32'h0000_17FE};
    tbl[10] = '{10'h3FE, 4'h5, 0,  1'b1, 32'hC,  32'hFFFF, 1'b0, 32'h0};
    tbl[11] = '{10'h3FE, 4'h5, 0,  1'b0, 32'hC,  32'h0,    1'b1, 32'h0};
    tbl[12] = '{10'h3FE, 4'h5, 0,  1'b1, 32'h8,  32'hFFFF, 1'b0, 32'h0};
    tbl[13] = '{10'h3FE, 4'h5, 0,  1'b0, 32'h8,  32'h0,    1'b1, mask_exp};
    tbl[14] = '{10'h3FE, 4'h5, 0,  1'b0, 32'h14, 32'h0,    1'b1, 32'h0000_1000};
    tbl[15] = '{10'h3FE, 4'h5, 0,  1'b1, 32'h4,  32'h3FFF, 1'b0, 32'h0};
    tbl[16] = '{10'h3FE, 4'h5, 0,  1'b0, 32'h4,  32'h0,    1'b1, 32'h0};

    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    sw = 10'h3FF;
    btn = 4'h0;
    bus_if.i_enable  = 1'b0;
    bus_if.i_rw      = 1'b0;
    bus_if.i_address = 32'h0;
    bus_if.i_wdata   = 32'h0;

    tick(3);
    check("reset_ready", {31'b0, bus_if.o_ready}, 32'd0);
    check("reset_rdata", bus_if.o_rdata, 32'd0);
    check("reset_irq", {31'b0, irq}, 32'd0);
    check("reset_state", {18'b0, dut.state_vec}, 32'd0);
    rst = 1'b0;

    // startup settling: levels present at reset must not become events
    tick(10);
    rd("settle_state", 32'h0, 32'h0000_03FF);
    rd("settle_edges", 32'h4, 32'h0);
    check("settle_irq", {31'b0, irq}, 32'd0);

    for (int i = 0; i < 17; i++) begin
      sw  = tbl[i].sw;
      btn = tbl[i].btn;
      tick(tbl[i].settle);
      bus_access(tbl[i].rw, tbl[i].addr, tbl[i].wdata, r);
      if (tbl[i].chk) check($sformatf("vec%0d", i), r, tbl[i].exp);
    end

    // switch0 0->1: STATE must follow exactly 6 edges later
    sw = 10'h3FF;
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      if (c == 5) check("latency_before", {31'b0, dut.state_vec[0]}, 32'd0);
      if (c == 6) check("latency_after", {31'b0, dut.state_vec[0]}, 32'd1);
    end
    tick(4);
    rd("rise_edges", 32'h4, 32'h1);
    wr(32'h4, 32'h1);
    // 2-cycle glitch is dropped
    sw = 10'h3FE;
    tick(2);
    sw = 10'h3FF;
    tick(10);
    rd("glitch_state", 32'h0, 32'h0000_17FF);
    rd("glitch_edges", 32'h4, 32'h0);

`ifdef SWITCH_INPUT_IRQ_EN
    wr(32'h8, 32'h1);
    check("irq_masked_idle", {31'b0, irq}, 32'd0);
    sw = 10'h3FE;
    tick(10);
    check("irq_on_edge", {31'b0, irq}, 32'd1);
    bus_if.i_enable  = 1'b1;
    bus_if.i_rw      = 1'b1;
    bus_if.i_address = 32'h4;
    bus_if.i_wdata   = 32'h1;
    tick(1);
    check("irq_clear_ready", {31'b0, bus_if.o_ready}, 32'd1);
    check("irq_still_high", {31'b0, irq}, 32'd1);
    bus_if.i_enable = 1'b0;
    tick(1);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    rd("irq_edges_cleared", 32'h4, 32'h0);
`else
    wr(32'h8, 32'hFFFF);
    rd("nomask_read", 32'h8, 32'h0);
    sw = 10'h3FE;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (irq !== 1'b0) bad++;
    end
    check("noirq_on_edge", bad, 32'd0);
    rd("nomask_edges", 32'h4, 32'h1);
    wr(32'h4, 32'h1);
`endif

    // W1C of bit3 on the same edge that a new bit3 event lands
    sw = 10'h3F6;
    tick(10);
    rd("bit3_edge", 32'h4, 32'h8);
    sw = 10'h3FE;
    tick(5);
    wr(32'h4, 32'h8);
    rd("bit3_race_kept", 32'h4, 32'h8);
    wr(32'h4, 32'h8);
    rd("bit3_cleared", 32'h4, 32'h0);

    // held enable: one clear only; a later event during the hold survives
    sw = 10'h3FF;
    tick(10);
    rd("hold_pre_edges", 32'h4, 32'h1);
    sw = 10'h3FE;
    tick(3);
    bus_if.i_enable  = 1'b1;
    bus_if.i_rw      = 1'b1;
    bus_if.i_address = 32'h4;
    bus_if.i_wdata   = 32'h1;
    check("hold_ready_before", {31'b0, bus_if.o_ready}, 32'd0);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      if (bus_if.o_ready !== 1'b1) bad++;
    end
    check("hold_ready_high", bad, 32'd0);
    bus_if.i_enable = 1'b0;
    tick(1);
    check("hold_ready_drop", {31'b0, bus_if.o_ready}, 32'd0);
    check("hold_rdata_zero", bus_if.o_rdata, 32'd0);
    rd("hold_single_clear", 32'h4, 32'h1);

    // reset in the middle of an access
    bus_if.i_enable  = 1'b1;
    bus_if.i_rw      = 1'b1;
    bus_if.i_address = 32'h4;
    bus_if.i_wdata   = 32'h1;
    tick(1);
    check("mid_ready", {31'b0, bus_if.o_ready}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_reset_ready", {31'b0, bus_if.o_ready}, 32'd0);
    check("mid_reset_rdata", bus_if.o_rdata, 32'd0);
    bus_if.i_enable = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(12);
    rd("post_reset_state", 32'h0, 32'h0000_17FE);
    rd("post_reset_edges", 32'h4, 32'h0);
    rd("post_reset_mask", 32'h8, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
